// File: rtl/pe_layer_sequencer.sv
// Sequences one fully-connected layer onto a combinational sign-magnitude PE.
// Optional build macro SEQ_RELU_EN clamps negative PE results (sign bit set) to zero.

module pe_seq_lane #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         we_x,
  input  logic         we_w,
  input  logic [W-1:0] d_x,
  input  logic [W-1:0] d_w,
  output logic [W-1:0] in_q,
  output logic [W-1:0] wt_q
);
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      in_q <= '0;
      wt_q <= '0;
    end else begin
      if (we_x) in_q <= d_x;
      if (we_w) wt_q <= d_w;
    end
  end
endmodule

module pe_layer_sequencer #(
  parameter int N_IN  = 62,
  parameter int N_OUT = 16,
  parameter int W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              x_valid,
  output logic              x_ready,
  input  logic [W-1:0]      x_data,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [W-1:0]      w_data,
  output logic              y_valid,
  input  logic              y_ready,
  output logic [W-1:0]      y_data,
  output logic              y_last,
  output logic              busy,
  output logic              done,
  output logic [W-1:0]      pe_bias,
  output logic [N_IN*W-1:0] pe_weight,
  output logic [N_IN*W-1:0] pe_in,
  input  logic [W-1:0]      pe_out
);
  localparam int BW = $clog2(N_IN + 1);
  localparam int NW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [BW-1:0] LAST_X = BW'(N_IN - 1);
  localparam logic [BW-1:0] LAST_W = BW'(N_IN);
  localparam logic [NW-1:0] LAST_N = NW'(N_OUT - 1);

  typedef enum logic [2:0] {IDLE, LOAD_X, LOAD_W, EVAL, EMIT, DONE} state_t;
  state_t state, state_n;

  logic [BW-1:0] beat;
  logic [NW-1:0] neuron;
  logic [N_IN-1:0][W-1:0] lane_in, lane_wt;
  logic lane_clr;
  logic [W-1:0] y_cap;

  // Handshake outputs are pure state decodes, so no valid/ready input reaches an output.
  assign x_ready = (state == LOAD_X);
  assign w_ready = (state == LOAD_W);
  assign y_valid = (state == EMIT);
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

  assign lane_clr  = (state == IDLE) && start;
  assign pe_in     = lane_in;
  assign pe_weight = lane_wt;

`ifdef SEQ_RELU_EN
  assign y_cap = pe_out[W-1] ? '0 : pe_out;
`else
  assign y_cap = pe_out;
`endif

  // Weight beat 0 is the bias, so weight lane i is written on beat i+1.
  for (genvar i = 0; i < N_IN; i++) begin : g_lane
    pe_seq_lane #(.W(W)) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (lane_clr),
      .we_x (x_ready && x_valid && (beat == BW'(i))),
      .we_w (w_ready && w_valid && (beat == BW'(i + 1))),
      .d_x  (x_data),
      .d_w  (w_data),
      .in_q (lane_in[i]),
      .wt_q (lane_wt[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = LOAD_X;
      LOAD_X:  if (x_valid && beat == LAST_X) state_n = LOAD_W;
      LOAD_W:  if (w_valid && beat == LAST_W) state_n = EVAL;
      EVAL:    state_n = EMIT;
      EMIT:    if (y_ready) state_n = (neuron == LAST_N) ? DONE : LOAD_W;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat    <= '0;
      neuron  <= '0;
      pe_bias <= '0;
      y_data  <= '0;
      y_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          beat    <= '0;
          neuron  <= '0;
          pe_bias <= '0;
        end
        LOAD_X: if (x_valid) beat <= (beat == LAST_X) ? '0 : beat + 1'b1;
        LOAD_W: if (w_valid) begin
          if (beat == '0) pe_bias <= w_data;
          beat <= (beat == LAST_W) ? '0 : beat + 1'b1;
        end
        EVAL: begin
          y_data <= y_cap;
          y_last <= (neuron == LAST_N);
        end
        EMIT: if (y_ready && neuron != LAST_N) begin
          neuron <= neuron + 1'b1;
          beat   <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pe_layer_sequencer.sv
// Bench for pe_layer_sequencer: stub PE plus a per-layer array model of the expected results.
module tb_pe_layer_sequencer;
  localparam int N_IN  = 62;
  localparam int N_OUT = 3;
  localparam int W     = 8;
  localparam int WB    = N_IN + 1;
`ifdef SEQ_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, start, x_valid, w_valid, y_ready;
  logic [W-1:0] x_data, w_data, pe_out, y_data, pe_bias;
  logic x_ready, w_ready, y_valid, y_last, busy, done;
  logic [N_IN*W-1:0] pe_weight, pe_in;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pe_layer_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .y_last(y_last),
    .busy(busy), .done(done),
    .pe_bias(pe_bias), .pe_weight(pe_weight), .pe_in(pe_in), .pe_out(pe_out)
  );

  // Stub PE: either a constant, or a lane-order-sensitive checksum of its operands.
  bit pe_mode;
  logic [7:0] pe_const;
  always_comb begin
    int acc;
    acc = int'(pe_bias);
    for (int i = 0; i < N_IN; i++)
      acc += int'(pe_in[i*W +: W]) * int'(pe_weight[i*W +: W] ^ 8'(i));
    pe_out = pe_mode ? pe_const : 8'(acc);
  end

  int xv[N_IN];
  int wv[N_OUT][WB];
  logic [7:0] ey[N_OUT];

  function automatic logic [7:0] model_y(int n);
    int acc = wv[n][0];
    for (int i = 0; i < N_IN; i++) acc += xv[i] * (wv[n][i+1] ^ i);
    acc = acc & 255;
    if (RELU && acc >= 128) acc = 0;
    return 8'(acc);
  endfunction

  task automatic chk(input string name, input logic [N_IN*W-1:0] act, input logic [N_IN*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic run_layer(input bit mode, input logic [7:0] cval, input int gap,
                           input int stall, input bit abuse, input logic [7:0] cexp);
    int xi, wi, yi, stallc, cyc, last_w, done_at;
    bit fin, on;
    logic [N_IN*W-1:0] exp_in, exp_wt;
    pe_mode = mode;
    pe_const = cval;
    for (int i = 0; i < N_IN; i++) xv[i] = $urandom_range(0, 255);
    for (int n = 0; n < N_OUT; n++)
      for (int j = 0; j < WB; j++) wv[n][j] = $urandom_range(0, 255);
    for (int n = 0; n < N_OUT; n++) ey[n] = mode ? cexp : model_y(n);
    for (int i = 0; i < N_IN; i++) exp_in[i*W +: W] = 8'(xv[i]);
    xi = 0; wi = 0; yi = 0; stallc = 0; last_w = -10; done_at = -10; fin = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (cyc = 0; cyc < 20000 && !fin; cyc++) begin
      on = (gap == 0) || (cyc % 2 == 0);
      start = abuse && (cyc == 5);
      x_valid = on && xi < N_IN;
      x_data = (xi < N_IN) ? 8'(xv[xi]) : 8'($urandom);
      if (abuse && xi >= N_IN) begin x_valid = 1'b1; x_data = 8'($urandom); end
      w_valid = on && wi < N_OUT * WB;
      w_data = (wi < N_OUT * WB) ? 8'(wv[wi / WB][wi % WB]) : 8'h00;
      if (abuse && x_ready) begin w_valid = 1'b1; w_data = 8'($urandom); end
      y_ready = (stallc >= stall);
      chk("ready_onehot", 496'($countones({x_ready, w_ready, y_valid}) <= 1), 496'(1));
      chk("done_pulse", 496'(done), 496'(cyc == done_at));
      if (x_ready) chk("x_phase_wt_clear", 496'(|{pe_bias, pe_weight}), 496'(0));
      if (x_valid && x_ready) xi++;
      if (w_valid && w_ready) begin
        wi++;
        if (wi % WB == 0) last_w = cyc;
      end
      if (cyc == last_w + 1) chk("eval_no_valid", 496'(y_valid), 496'(0));
      if (cyc == last_w + 2) chk("y_latency", 496'(y_valid), 496'(1));
      if (y_valid) begin
        for (int i = 0; i < N_IN; i++) exp_wt[i*W +: W] = 8'(wv[yi][i+1]);
        chk("y_data", 496'(y_data), 496'(ey[yi]));
        chk("y_last", 496'(y_last), 496'(yi == N_OUT - 1));
        chk("pe_in", pe_in, exp_in);
        chk("pe_weight", pe_weight, exp_wt);
        chk("pe_bias", 496'(pe_bias), 496'(wv[yi][0]));
        if (y_ready) begin
          yi++;
          stallc = 0;
          if (yi == N_OUT) done_at = cyc + 1;
        end else stallc++;
      end
      if (cyc == done_at) chk("busy_in_done", 496'(busy), 496'(1));
      if (cyc == done_at + 1) begin
        chk("idle_after_done", 496'(busy), 496'(0));
        fin = 1;
      end
      @(negedge clk);
    end
    if (!fin) chk("layer_timeout", 496'(0), 496'(1));
    chk("x_beats", 496'(xi), 496'(N_IN));
    chk("w_beats", 496'(wi), 496'(N_OUT * WB));
    chk("results", 496'(yi), 496'(N_OUT));
    x_valid = 1'b0; w_valid = 1'b0; start = 1'b0; y_ready = 1'b0;
  endtask

  typedef struct {
    bit mode; logic [7:0] cval; int gap; int stall; bit abuse; logic [7:0] exp_y;
  } vec_t;
  vec_t tbl[8];

  initial begin
    int wcount;
    tbl[0] = '{0, 8'h00, 0, 0, 0, 8'h00};
    tbl[1] = '{0, 8'h00, 1, 0, 0, 8'h00};
    tbl[2] = '{0, 8'h00, 0, 5, 0, 8'h00};
    tbl[3] = '{0, 8'h00, 1, 5, 1, 8'h00};
    tbl[4] = '{1, 8'h85, 0, 0, 0, RELU ? 8'h00 : 8'h85};
    tbl[5] = '{1, 8'h7F, 0, 0, 0, 8'h7F};
    tbl[6] = '{1, 8'h80, 1, 2, 0, RELU ? 8'h00 : 8'h80};
    tbl[7] = '{1, 8'h00, 0, 1, 1, 8'h00};
    pe_mode = 0; pe_const = 0;
    x_valid = 0; w_valid = 0; y_ready = 0; x_data = 0; w_data = 0;
    // reset wins over a simultaneous start
    rst_n = 1'b0; start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("reset_outputs", 496'(|{x_ready, w_ready, y_valid, y_data, y_last, busy, done,
                                   pe_bias, pe_weight, pe_in}), 496'(0));
    end
    rst_n = 1'b1; start = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", 496'(busy), 496'(0));

    for (int t = 0; t < 8; t++)
      run_layer(tbl[t].mode, tbl[t].cval, tbl[t].gap, tbl[t].stall, tbl[t].abuse, tbl[t].exp_y);

    // partial layer interrupted by reset mid-LOAD_W
    pe_mode = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wcount = 0;
    for (int c = 0; c < 500 && wcount < 10; c++) begin
      x_valid = 1'b1; x_data = 8'($urandom);
      w_valid = 1'b1; w_data = 8'($urandom);
      if (w_ready) wcount++;
      @(negedge clk);
    end
    chk("reached_load_w", 496'(wcount), 496'(10));
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("mid_layer_reset", 496'(|{x_ready, w_ready, y_valid, y_data, y_last, busy, done,
                                     pe_bias, pe_weight, pe_in}), 496'(0));
    end
    rst_n = 1'b1; x_valid = 1'b0; w_valid = 1'b0;
    @(negedge clk);
    run_layer(0, 8'h00, 0, 0, 0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pe_layer_sequencer.md
# pe_layer_sequencer

Sequencer that time-multiplexes one fully-connected layer onto the combinational sign-magnitude PE. It streams in the layer's input vector once, then streams one bias plus N_IN weights per output neuron. For each neuron it drives the PE operand buses, samples the PE result and emits it on a valid/ready output stream. It sits between the weight/activation memory readers and the downstream activation buffer.

## Interface
- N_IN, 62, number of input lanes (PE fan-in); lane i occupies bits [8i+7:8i]
- N_OUT, 16, number of output neurons sequenced per layer
- W, 8, operand width; sign-magnitude, bit W-1 is sign
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin layer; sampled only in IDLE
- x_valid / x_ready  in / out  1  input-activation stream handshake
- x_data  in  W  one activation per beat, lane 0 first
- w_valid / w_ready  in / out  1  weight stream handshake
- w_data  in  W  per neuron: bias beat, then weight lanes 0..N_IN-1
- y_valid / y_ready  out / in  1  result stream handshake
- y_data  out  W  neuron result
- y_last  out  1  high with the result of neuron N_OUT-1
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last result is accepted
- pe_bias  out  W  to PE bias
- pe_weight  out  N_IN*W  to PE weight
- pe_in  out  N_IN*W  to PE in
- pe_out  in  W  from PE out (combinational in PE)

## Operation
- A beat transfers on a rising edge where valid && ready.
- States: IDLE, LOAD_X, LOAD_W, EVAL, EMIT, DONE.
- IDLE
  - All readies low.
  - On start: clear pe_in, pe_weight, pe_bias, lane counter and neuron counter, then go to LOAD_X.
- LOAD_X
  - x_ready=1.
  - Beat k is written to pe_in lane k.
  - After beat N_IN-1: go to LOAD_W, neuron=0, beat=0.
- LOAD_W
  - w_ready=1.
  - Beat 0 is written to pe_bias.
  - Beat j (1..N_IN) is written to pe_weight lane j-1.
  - After beat N_IN: go to EVAL.
- EVAL
  - One cycle; no readies asserted.
  - Register pe_out (after the optional ReLU, see Configuration) into y_data.
  - Set y_last = (neuron == N_OUT-1).
  - Go to EMIT.
- EMIT
  - y_valid=1.
  - On acceptance: if neuron==N_OUT-1, go to DONE; else neuron+1, beat=0, go to LOAD_W.
- DONE
  - done=1 for this cycle only, then go to IDLE.
- pe_in holds for the whole layer.
- pe_weight lanes keep the previous neuron's values until overwritten.
- The PE operands are only sampled in EVAL, after all lanes are loaded.
- Counters are sized $clog2 of their range and wrap only through the explicit resets above.

## Timing
- Reset value of every output is 0:
  - x_ready, w_ready, y_valid, y_data, y_last, busy, done, pe_bias, pe_weight, pe_in.
  - State resets to IDLE.
- All outputs are registered or decoded from state only; there is no combinational path from valid/ready inputs to outputs.
- Latency:
  - Last weight beat accepted at edge t → EVAL during cycle t+1 → y_valid high from edge t+2.
  - The first LOAD_W beat of the next neuron can be accepted at the edge after the result is accepted.
- Minimum layer length: 1 + N_IN + N_OUT·(N_IN+1+2) + 1 cycles with no stalls.
- y_data and y_last stay stable while y_valid && !y_ready.
- Boundary conditions:
  - start while busy: ignored.
  - x_valid outside LOAD_X and w_valid outside LOAD_W: ignored, no state change.
  - Valid deasserted mid-vector: counters hold; loading resumes on the next beat.
  - rst_n low in any state: next edge returns every output to 0 and state to IDLE; a partial layer is discarded.
  - start high together with rst_n low: reset wins.

## Configuration
- SEQ_RELU_EN defined:
  - In EVAL, if pe_out[W-1]==1, y_data is captured as 0. This covers negative zero 8'h80.
  - Otherwise pe_out is captured unchanged.
- SEQ_RELU_EN undefined: pe_out is captured unchanged, including the sign bit.

## Test plan
- Reset check: hold rst_n=0 for 3 cycles mid-LOAD_W → all outputs 0, busy=0. Then a new start completes a layer normally.
- Single neuron, N_OUT=1, real PE:
  - Stimulus: inputs all 0, bias 0, weights lanes 0..3 = 8'h85, 8'h04, 8'h83, 8'h02, rest 0.
  - Expected: y_data=0, y_last=1, y_valid high 2 edges after the last weight beat, done pulses one cycle after acceptance.
- ReLU via stubbed PE (pe_out forced to 8'h85):
  - With SEQ_RELU_EN: y_data=8'h00.
  - Without: y_data=8'h85.
  - Stub pe_out=8'h7F → 8'h7F in both builds.
- Backpressure, N_OUT=3:
  - Stimulus: hold y_ready=0 for 5 cycles on each result.
  - Expected: y_data stable while stalled; w_ready=0 during EMIT; exactly 3 results; y_last only on the third.
- Stream gaps: x_valid and w_valid toggle 1/0 every cycle → identical results to the no-gap run; the beat count is exact with no skipped or duplicated lanes.
- Protocol abuse: start pulsed in LOAD_X, and w_valid high during LOAD_X → no restart, no pe_bias/pe_weight change.
